// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator running on the 50 MHz clock with an internal
// one-in-two pixel tick; sync/blank flags are registered alongside the counters.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk_50m,
    input  logic       rst,
    output logic       pix_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start
);

    // Totals must fit the 10-bit counters (at most 1024 each).
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync pulse ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
    localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]  x_next;
    logic [9:0]  y_next;
    logic [10:0] x_next_w;
    logic [10:0] y_next_w;
    logic        frame_wrap;

    always_comb begin
        x_next     = pixel_x;
        y_next     = pixel_y;
        frame_wrap = 1'b0;
        if (pix_tick) begin
            if (pixel_x == H_LAST) begin
                x_next = '0;
                if (pixel_y == V_LAST) begin
                    y_next     = '0;
                    frame_wrap = 1'b1;
                end else begin
                    y_next = pixel_y + 10'd1;
                end
            end else begin
                x_next = pixel_x + 10'd1;
            end
        end
        x_next_w = {1'b0, x_next};
        y_next_w = {1'b0, y_next};
    end

    // Flags are derived from the next counter values so they line up with
    // pixel_x/pixel_y in the same cycle.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            pix_tick    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_tick    <= ~pix_tick;
            pixel_x     <= x_next;
            pixel_y     <= y_next;
            hsync       <= !((x_next_w >= HS_START) && (x_next_w < HS_END));
            vsync       <= !((y_next_w >= VS_START) && (y_next_w < VS_END));
            video_on    <= (x_next_w < H_VIS_END) && (y_next_w < V_VIS_END);
            frame_start <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance for reset/line timing and a
// shrunken instance (32-cycle lines, 224-cycle frames) for frame-level behaviour.
module tb_vga_sync_gen;

    logic       clk_50m = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic       tick_a, hs_a, vs_a, von_a, fs_a;
    logic       tick_b, hs_b, vs_b, von_b, fs_b;
    logic [9:0] x_a, y_a, x_b, y_b;
    logic [24:0] got_a, got_b;

    int n_cmp  = 0;
    int n_fail = 0;
    // Cycles since the first edge with reset low (E-index); -1 while in reset.
    int ka = -1;
    int kb = -1;

    localparam logic [24:0] RESET_VEC = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};

    always #10 clk_50m = ~clk_50m;

    vga_sync_gen dut_a (
        .clk_50m(clk_50m), .rst(rst_a), .pix_tick(tick_a), .pixel_x(x_a), .pixel_y(y_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(von_a), .frame_start(fs_a)
    );

    vga_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut_b (
        .clk_50m(clk_50m), .rst(rst_b), .pix_tick(tick_b), .pixel_x(x_b), .pixel_y(y_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(von_b), .frame_start(fs_b)
    );

    assign got_a = {tick_a, x_a, y_a, hs_a, vs_a, von_a, fs_a};
    assign got_b = {tick_b, x_b, y_b, hs_b, vs_b, von_b, fs_b};

    always @(posedge clk_50m) begin
        ka <= rst_a ? -1 : ka + 1;
        kb <= rst_b ? -1 : kb + 1;
    end

    // Reference: every output is a pure function of the elapsed cycle count.
    // Pixel index p = (k+1)/2; coordinates and flags follow from p by division.
    function automatic logic [24:0] model(int k, int hv, int hf, int hsw, int hb,
                                          int vv, int vf, int vsw, int vb);
        int ht, vt, p, pf, x, y;
        logic t, h, v, on, f;
        if (k < 0) return RESET_VEC;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        p  = (k + 1) / 2;
        pf = p % (ht * vt);
        x  = pf % ht;
        y  = pf / ht;
        t  = (k % 2 == 0);
        h  = !(x >= hv + hf && x < hv + hf + hsw);
        v  = !(y >= vv + vf && y < vv + vf + vsw);
        on = (x < hv) && (y < vv);
        f  = (k % 2 == 1) && (p > 0) && (pf == 0);
        return {t, 10'(x), 10'(y), h, v, on, f};
    endfunction

    function automatic logic [24:0] exp_a(int k);
        return model(k, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic logic [24:0] exp_b(int k);
        return model(k, 8, 2, 3, 3, 4, 1, 1, 1);
    endfunction

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (5) begin
            @(negedge clk_50m);
            n_cmp++;
            if (got_a !== RESET_VEC) begin
                n_fail++;
                $display("FAIL reset_a: got %h expected %h", got_a, RESET_VEC);
            end
            n_cmp++;
            if (got_b !== RESET_VEC) begin
                n_fail++;
                $display("FAIL reset_b: got %h expected %h", got_b, RESET_VEC);
            end
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic test_startup();
        logic [24:0] e;
        repeat (8) begin
            @(negedge clk_50m);
            e = exp_a(ka);
            n_cmp++;
            if (got_a !== e) begin
                n_fail++;
                $display("FAIL startup k=%0d: got %h expected %h", ka, got_a, e);
            end
            if (ka == 1 || ka == 3) begin
                n_cmp++;
                if (x_a !== 10'((ka + 1) / 2)) begin
                    n_fail++;
                    $display("FAIL startup_x k=%0d: got %0d expected %0d", ka, x_a, (ka + 1) / 2);
                end
            end
        end
    endtask

    task automatic test_line();
        int hs_first = -1, hs_low = 0, von_first = -1, von_low = 0, nf = 0;
        logic [24:0] e;
        while (ka < 3250 && nf < 20) begin
            @(negedge clk_50m);
            e = exp_a(ka);
            n_cmp++;
            if (got_a !== e) begin
                n_fail++;
                nf++;
                $display("FAIL line k=%0d: got %h expected %h", ka, got_a, e);
            end
            if (ka < 1599) begin
                if (!hs_a) begin
                    if (hs_first < 0) hs_first = ka;
                    hs_low++;
                end
                if (!von_a) begin
                    if (von_first < 0) von_first = ka;
                    von_low++;
                end
            end
            if (ka == 1599) begin
                n_cmp++;
                if (x_a !== 10'd0 || y_a !== 10'd1) begin
                    n_fail++;
                    $display("FAIL line_wrap: got (%0d,%0d) expected (0,1)", x_a, y_a);
                end
            end
        end
        n_cmp++;
        if (hs_first != 1311 || hs_low != 192) begin
            n_fail++;
            $display("FAIL hsync_pulse: start %0d len %0d expected start 1311 len 192", hs_first, hs_low);
        end
        n_cmp++;
        if (von_first != 1279 || von_low != 320) begin
            n_fail++;
            $display("FAIL blank_pulse: start %0d len %0d expected start 1279 len 320", von_first, von_low);
        end
    endtask

    task automatic test_reset_mid_line();
        int guard = 0, nf = 0;
        logic [24:0] e;
        e = exp_a(ka);
        while (e[23:14] != 10'd700 && guard < 2000) begin
            @(negedge clk_50m);
            guard++;
            e = exp_a(ka);
        end
        repeat ($urandom_range(0, 1)) @(negedge clk_50m);
        n_cmp++;
        if (hs_a !== 1'b0 || x_a !== 10'd700) begin
            n_fail++;
            $display("FAIL pre_reset: got hsync %b x %0d expected hsync 0 x 700", hs_a, x_a);
        end
        rst_a = 1'b1;
        @(negedge clk_50m);
        n_cmp++;
        if (got_a !== RESET_VEC) begin
            n_fail++;
            $display("FAIL mid_reset: got %h expected %h", got_a, RESET_VEC);
        end
        rst_a = 1'b0;
        repeat (1700) begin
            @(negedge clk_50m);
            if (nf < 20) begin
                e = exp_a(ka);
                n_cmp++;
                if (got_a !== e) begin
                    n_fail++;
                    nf++;
                    $display("FAIL after_reset k=%0d: got %h expected %h", ka, got_a, e);
                end
            end
        end
    endtask

    task automatic test_frames_small();
        int fs_q[$];
        int hs_falls = 0, von_high = 0, vs_low = 0, nf = 0;
        logic prev_hs = 1'b1;
        logic [24:0] e;
        rst_b = 1'b1;
        @(negedge clk_50m);
        rst_b = 1'b0;
        while (kb < 3 * 224 + 20 && nf < 20) begin
            @(negedge clk_50m);
            e = exp_b(kb);
            n_cmp++;
            if (got_b !== e) begin
                n_fail++;
                nf++;
                $display("FAIL frame_b k=%0d: got %h expected %h", kb, got_b, e);
            end
            if (fs_b === 1'b1) fs_q.push_back(kb);
            if (kb >= 223 && kb < 447) begin
                if (prev_hs && !hs_b) hs_falls++;
                if (von_b) von_high++;
                if (!vs_b) vs_low++;
            end
            prev_hs = hs_b;
        end
        n_cmp++;
        if (fs_q.size() != 3) begin
            n_fail++;
            $display("FAIL fs_count: got %0d expected 3", fs_q.size());
        end else begin
            n_cmp++;
            if (fs_q[0] != 223 || fs_q[1] - fs_q[0] != 224 || fs_q[2] - fs_q[1] != 224) begin
                n_fail++;
                $display("FAIL fs_spacing: got %0d,%0d,%0d expected 223,447,671", fs_q[0], fs_q[1], fs_q[2]);
            end
        end
        n_cmp++;
        if (hs_falls != 7 || von_high != 64 || vs_low != 32) begin
            n_fail++;
            $display("FAIL frame_stats: hs_falls %0d von_high %0d vs_low %0d expected 7 64 32",
                     hs_falls, von_high, vs_low);
        end
    endtask

    task automatic test_random_resets();
        int nf = 0, guard;
        logic [24:0] e;
        for (int it = 0; it < 6; it++) begin
            if (it == 0) begin
                guard = 0;
                e = exp_b(kb);
                while (!(e[23:14] == 10'd11 && e[13:4] == 10'd5) && guard < 300) begin
                    @(negedge clk_50m);
                    guard++;
                    e = exp_b(kb);
                end
            end else begin
                repeat ($urandom_range(1, 300)) begin
                    @(negedge clk_50m);
                    if (nf < 20) begin
                        e = exp_b(kb);
                        n_cmp++;
                        if (got_b !== e) begin
                            n_fail++;
                            nf++;
                            $display("FAIL rand_run k=%0d: got %h expected %h", kb, got_b, e);
                        end
                    end
                end
            end
            rst_b = 1'b1;
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk_50m);
                n_cmp++;
                if (got_b !== RESET_VEC) begin
                    n_fail++;
                    $display("FAIL rand_reset it=%0d: got %h expected %h", it, got_b, RESET_VEC);
                end
            end
            rst_b = 1'b0;
        end
        repeat (250) begin
            @(negedge clk_50m);
            if (nf < 20) begin
                e = exp_b(kb);
                n_cmp++;
                if (got_b !== e) begin
                    n_fail++;
                    nf++;
                    $display("FAIL rand_tail k=%0d: got %h expected %h", kb, got_b, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_line();
        test_reset_mid_line();
        test_frames_small();
        test_random_resets();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
